// File: rtl/i2s_fm_ctrl.sv
// Moves I2S stereo frames into the clk domain and mixes/scales them onto the carrier.
// Offers the resulting tuning word to the DDS; a watchdog falls back to the bare carrier.
//
// state | meaning
// IDLE  | waiting for a frame strobe or watchdog expiry
// CALC  | one cycle: form carrier + deviation into freq_word
// OFFER | freq_word valid, waiting for freq_ready
module i2s_fm_ctrl #(
    parameter int SAMPLE_W  = 16,
    parameter int DEV_SHIFT = 8,
    parameter int TIMEOUT   = 100000,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [31:0]       carrier_word,
    input  logic [31:0]       first_channel,
    input  logic [31:0]       second_channel,
    input  logic              data_updated,
    output logic [31:0]       freq_word,
    output logic              freq_valid,
    input  logic              freq_ready,
    output logic              signal_lost,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  overrun_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CALC, OFFER} state_t;

    state_t                state, state_nxt;
    logic [2:0]            du_sync;
    logic                  strobe;
    logic [SAMPLE_W-1:0]   samp_l, samp_r;
    logic [SAMPLE_W:0]     sum;
    logic [SAMPLE_W-1:0]   mix;
    logic [31:0]           mix_ext, dev;
    logic [WD_W-1:0]       wd_cnt;
    logic                  wd_fire;
    logic                  mute, mute_nxt;
    logic                  load_word, accept, overrun;

    // du_sync[2] is the history bit used only for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            du_sync <= '0;
        end else begin
            du_sync <= {du_sync[1:0], data_updated};
        end
    end

    assign strobe = du_sync[1] & ~du_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_l <= '0;
            samp_r <= '0;
        end else if (strobe) begin
            samp_l <= first_channel[31 -: SAMPLE_W];
            samp_r <= second_channel[31 -: SAMPLE_W];
        end
    end

    assign sum = {samp_l[SAMPLE_W-1], samp_l} + {samp_r[SAMPLE_W-1], samp_r};

    always_comb begin
        mix = '0;
        if (!mute) begin
            case (mode)
                2'd0:    mix = sum[SAMPLE_W:1];
                2'd1:    mix = samp_l;
                2'd2:    mix = samp_r;
                default: mix = '0;
            endcase
        end
    end

    assign mix_ext = {{(32-SAMPLE_W){mix[SAMPLE_W-1]}}, mix};
    assign dev     = mix_ext << DEV_SHIFT;

    // wd_fire is a single-cycle pulse on the cycle the count lands on TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            wd_fire     <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            wd_fire <= 1'b0;
            if (strobe) begin
                wd_cnt      <= '0;
                signal_lost <= 1'b0;
            end else if (enable && wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    signal_lost <= 1'b1;
                    wd_fire     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mute  <= 1'b0;
        end else begin
            state <= state_nxt;
            mute  <= mute_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mute_nxt  = mute;
        load_word = 1'b0;
        accept    = 1'b0;
        overrun   = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        state_nxt = CALC;
                        mute_nxt  = 1'b0;
                    end else if (wd_fire) begin
                        state_nxt = CALC;
                        mute_nxt  = 1'b1;
                    end
                end
                CALC: begin
                    load_word = 1'b1;
                    state_nxt = OFFER;
                    // a frame landing here replaces the one being computed
                    if (strobe) begin
                        state_nxt = CALC;
                        mute_nxt  = 1'b0;
                        overrun   = 1'b1;
                    end
                end
                OFFER: begin
                    if (freq_ready) begin
                        accept    = 1'b1;
                        state_nxt = IDLE;
                    end else if (strobe) begin
                        overrun   = 1'b1;
                    end
                    if (strobe) begin
                        state_nxt = CALC;
                        mute_nxt  = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign freq_valid = (state == OFFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_word     <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            if (load_word) begin
                freq_word <= carrier_word + dev;
            end
            if (accept) begin
                frame_count <= frame_count + CNT_W'(1);
            end
            if (overrun && overrun_count != '1) begin
                overrun_count <= overrun_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_fm_ctrl.sv
// Scoreboard bench for i2s_fm_ctrl: expected tuning words are queued as frames are sent
// and popped when the DDS handshake completes.
module tb_i2s_fm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] carrier_word = 32'h1000_0000;
    logic [31:0] first_channel = '0;
    logic [31:0] second_channel = '0;
    logic        data_updated = 1'b0;
    logic [31:0] freq_word;
    logic        freq_valid;
    logic        freq_ready = 1'b1;
    logic        signal_lost;
    logic [15:0] frame_count;
    logic [15:0] overrun_count;

    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_frames = 0;

    i2s_fm_ctrl #(
        .SAMPLE_W(16), .DEV_SHIFT(8), .TIMEOUT(64), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .carrier_word(carrier_word), .first_channel(first_channel),
        .second_channel(second_channel), .data_updated(data_updated),
        .freq_word(freq_word), .freq_valid(freq_valid), .freq_ready(freq_ready),
        .signal_lost(signal_lost), .frame_count(frame_count),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] car,
                                          input logic [31:0] f, input logic [31:0] s);
        logic [15:0] lh, rh;
        int l, r, mix;
        lh = f[31:16];
        rh = s[31:16];
        l = int'($signed(lh));
        r = int'($signed(rh));
        case (m)
            2'd0:    mix = (l + r) >>> 1;
            2'd1:    mix = l;
            2'd2:    mix = r;
            default: mix = 0;
        endcase
        return car + 32'(mix <<< 8);
    endfunction

    // handshake monitor: every accepted word must have been predicted
    always @(negedge clk) begin
        if (rst_n && freq_valid && freq_ready) begin
            chk("sb_avail", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("freq_word", freq_word, sb.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        sb.push_back(w);
        exp_frames++;
    endtask

    task automatic send(input logic [31:0] f, input logic [31:0] s);
        first_channel  = f;
        second_channel = s;
        data_updated   = 1'b1;
        tick(4);
        data_updated   = 1'b0;
        tick(4);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("rst_valid", 32'(freq_valid), 32'd0);
        chk("rst_word", freq_word, 32'd0);
        chk("rst_lost", 32'(signal_lost), 32'd1);
        chk("rst_frames", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        tick(2);
        enable = 1'b1;

        // mono positive with exact valid timing
        push(32'h1040_0000);
        first_channel = 32'h4000_0000;
        second_channel = 32'h4000_0000;
        data_updated = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) chk("valid_edge2", 32'(freq_valid), 32'd0);
        @(posedge clk);
        @(negedge clk) chk("valid_edge3", 32'(freq_valid), 32'd1);
        tick(1);
        data_updated = 1'b0;
        tick(4);
        wait_drain(20);
        chk("frames1", 32'(frame_count), 32'd1);
        chk("lost_clear", 32'(signal_lost), 32'd0);

        push(32'h0FC0_0000);
        send(32'hC000_0000, 32'hC000_0000);
        push(32'h0FFF_FF00);
        send(32'h7FFF_0000, 32'h8000_0000);
        mode = 2'd1;
        push(32'h1000_0100);
        send(32'h0001_0000, 32'h5555_0000);
        mode = 2'd2;
        push(model(2'd2, carrier_word, 32'h1111_0000, 32'hF00D_0000));
        send(32'h1111_0000, 32'hF00D_0000);
        mode = 2'd3;
        push(model(2'd3, carrier_word, 32'h1234_0000, 32'h7654_0000));
        send(32'h1234_0000, 32'h7654_0000);
        wait_drain(20);
        chk("frames_modes", 32'(frame_count), 32'(exp_frames));

        // overrun: newest wins, only one accept
        mode = 2'd0;
        freq_ready = 1'b0;
        push(32'h1000_0300);
        send(32'h0001_0000, 32'h0001_0000);
        send(32'h0002_0000, 32'h0002_0000);
        send(32'h0003_0000, 32'h0003_0000);
        chk("ovr_count", 32'(overrun_count), 32'd2);
        chk("ovr_valid", 32'(freq_valid), 32'd1);
        chk("ovr_word", freq_word, 32'h1000_0300);
        freq_ready = 1'b1;
        wait_drain(20);
        chk("ovr_frames", 32'(frame_count), 32'(exp_frames));

        carrier_word = 32'hFFFF_FF00;
        push(32'h0000_0000);
        send(32'h0001_0000, 32'h0001_0000);
        wait_drain(20);
        carrier_word = 32'h1000_0000;

        // enable dropped while in CALC
        first_channel = 32'h0004_0000;
        second_channel = 32'h0004_0000;
        data_updated = 1'b1;
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        tick(2);
        data_updated = 1'b0;
        tick(6);
        chk("en_valid", 32'(freq_valid), 32'd0);
        chk("en_frames", 32'(frame_count), 32'(exp_frames));

        // watchdog fallback to the bare carrier
        mode = 2'd1;
        enable = 1'b1;
        chk("wd_lost0", 32'(signal_lost), 32'd0);
        tick(40);
        chk("wd_lost_early", 32'(signal_lost), 32'd0);
        push(32'h1000_0000);
        for (int i = 0; i < 100 && !freq_valid; i++) tick(1);
        chk("wd_valid", 32'(freq_valid), 32'd1);
        chk("wd_lost1", 32'(signal_lost), 32'd1);
        wait_drain(10);
        tick(80);
        chk("wd_lost_held", 32'(signal_lost), 32'd1);
        mode = 2'd0;
        push(32'h1000_0100);
        send(32'h0001_0000, 32'h0001_0000);
        chk("wd_lost_clr", 32'(signal_lost), 32'd0);
        wait_drain(20);
        chk("wd_frames", 32'(frame_count), 32'(exp_frames));

        // asynchronous reset while offering
        freq_ready = 1'b0;
        send(32'h0005_0000, 32'h0005_0000);
        chk("pre_rst_valid", 32'(freq_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(freq_valid), 32'd0);
        chk("arst_frames", 32'(frame_count), 32'd0);
        chk("arst_ovr", 32'(overrun_count), 32'd0);
        chk("arst_word", freq_word, 32'd0);
        chk("arst_lost", 32'(signal_lost), 32'd1);
        exp_frames = 0;
        tick(2);
        rst_n = 1'b1;
        freq_ready = 1'b1;
        tick(1);
        push(32'h1000_0200);
        send(32'h0002_0000, 32'h0002_0000);
        wait_drain(20);
        chk("post_rst_frames", 32'(frame_count), 32'(exp_frames));
        enable = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
